key_event_queue: RTL and testbench

- Buffers debounced keypad events between the debouncer/decoder front end and the two-digit sliding display stage.
- Each accepted key press becomes one 4-bit hex code in a small first-word-fall-through (FWFT) FIFO, drained over a valid/ready handshake.
- Prevents lost presses when the display stage stalls, and suppresses an identical code repeated within a hold-off window (contact chatter that escaped the debouncer).

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/key_fifo_mem.sv | 97 +++++++++
 rtl/key_event_queue.sv | 95 +++++++++
 tb/tb_key_event_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and defaults for the keypad event path.
//   key_code_t      : 4-bit hex key code
//   KEY_NONE        : code presented on out_code while the queue is empty
//   DEFAULT_DEPTH   : default FIFO depth (power of two, 2..16)
//   DEFAULT_HOLDOFF : default repeat-suppression window in clk cycles
//   timer_width()   : bit width needed for a hold-off down-counter
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_NONE        = 4'h0;
  localparam int        DEFAULT_DEPTH   = 4;
  localparam int        DEFAULT_HOLDOFF = 1000;

  // At least one bit so a disabled hold-off (0) still yields a legal vector.
  function automatic int timer_width(input int holdoff);
    if (holdoff < 2) return 1;
    return $clog2(holdoff + 1);
  endfunction

endpackage

// File: rtl/key_fifo_mem.sv
// key_fifo_mem
// First-word-fall-through storage for key codes: DEPTH x 4 array, wrapping
// read/write pointers and an occupancy counter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : synchronous flush (pushes/pops in the same cycle ignored)
//   push, wr_data : write request and data (dropped when full with no pop)
//   pop           : read request (ignored when empty)
//   push_accepted : combinational, this cycle's push will be stored
//   rd_data       : registered head entry, KEY_NONE when empty
//   count         : registered occupancy
//   full, empty   : decodes of count
module key_fifo_mem
  import keypad_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  key_code_t                  wr_data,
  input  logic                       pop,
  output logic                       push_accepted,
  output key_code_t                  rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  key_code_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     rd_ptr_next;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  key_code_t         head_reg;
  key_code_t         head_next;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  always_comb begin
    pop_ok      = pop && !empty && !clear && !rst;
    // A pop in the same cycle frees the slot a full FIFO needs.
    push_ok     = push && (!full || pop_ok) && !clear && !rst;
    // DEPTH is a power of two, so the pointers wrap naturally.
    rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    // The head register is refreshed from the array using next-state
    // pointers; when the slot about to become head is being written this
    // very cycle, the array still holds stale data, so forward wr_data.
    head_next = KEY_NONE;
    if (count_next != '0) begin
      if (push_ok && (wr_ptr_reg == rd_ptr_next))
        head_next = wr_data;
      else
        head_next = mem[rd_ptr_next];
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= KEY_NONE;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign push_accepted = push_ok;
  assign rd_data       = head_reg;
  assign count         = count_reg;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue
// Buffers debounced key presses for the display stage in a small FWFT FIFO
// and discards a repeat of the last accepted code inside a hold-off window.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   key_valid, key_code  : one-cycle press pulse and its hex code
//   clear                : synchronous flush of contents and all flags
//   out_valid, out_code  : head entry available / head code (0 when empty)
//   out_ready            : consumer takes the head this cycle
//   count                : current occupancy
//   overflow             : sticky, a press was dropped on a full FIFO
//   suppressed           : one-cycle pulse, a press was discarded by hold-off
module key_event_queue
  import keypad_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int HOLDOFF = DEFAULT_HOLDOFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  key_code_t              key_code,
  input  logic                   clear,
  output logic                   out_valid,
  output key_code_t              out_code,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   suppressed
);

  localparam int TW = timer_width(HOLDOFF);

  logic [TW-1:0] timer_reg;
  key_code_t     last_code_reg;
  logic          last_valid_reg;
  logic          overflow_reg;
  logic          suppressed_reg;

  logic          repeat_hit;
  logic          push_req;
  logic          pop_fire;
  logic          push_accepted;
  logic          fifo_full;
  logic          fifo_empty;

  // Repeat only counts while the window is still open; a zero timer (or
  // HOLDOFF=0, which never loads a nonzero value) lets every press through.
  assign repeat_hit = last_valid_reg && (key_code == last_code_reg) && (timer_reg != '0);
  assign push_req   = key_valid && !repeat_hit;
  assign out_valid  = !fifo_empty;
  assign pop_fire   = out_valid && out_ready;

  key_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .push          (push_req),
    .wr_data       (key_code),
    .pop           (pop_fire),
    .push_accepted (push_accepted),
    .rd_data       (out_code),
    .count         (count),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer_reg      <= '0;
      last_code_reg  <= KEY_NONE;
      last_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      suppressed_reg <= 1'b0;
    end else begin
      suppressed_reg <= key_valid && repeat_hit;
      // A dropped press does not become the "last accepted" code.
      if (push_req && fifo_full && !pop_fire)
        overflow_reg <= 1'b1;
      if (push_accepted) begin
        last_code_reg  <= key_code;
        last_valid_reg <= 1'b1;
        timer_reg      <= TW'(HOLDOFF);
      end else if (timer_reg != '0) begin
        timer_reg <= timer_reg - 1'b1;
      end
    end
  end

  assign overflow   = overflow_reg;
  assign suppressed = suppressed_reg;

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
// Directed bench for key_event_queue (DEPTH=4, HOLDOFF=10). Inputs change
// 1 time unit after a rising edge; outputs are observed at the same point.
module tb_key_event_queue;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  key_code_t  key_code = 4'h0;
  logic       clear = 1'b0;
  logic       out_valid;
  key_code_t  out_code;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       overflow;
  logic       suppressed;

  int errors = 0;
  int checks = 0;

  key_event_queue #(
    .DEPTH   (4),
    .HOLDOFF (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .out_ready  (out_ready),
    .count      (count),
    .overflow   (overflow),
    .suppressed (suppressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    key_valid = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input key_code_t code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_code !== 4'h0 ||
        overflow !== 1'b0 || suppressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b cnt=%0d code=%h ovf=%b sup=%b want v=0 cnt=0 code=0 ovf=0 sup=0",
               out_valid, count, out_code, overflow, suppressed);
    end
    $display("test_reset: done");
  endtask

  task automatic test_latency();
    push(4'hA);
    checks++;
    if (out_valid !== 1'b1 || out_code !== 4'hA || count !== 3'd1) begin
      errors++;
      $display("FAIL latency_first: got v=%b code=%h cnt=%0d want v=1 code=a cnt=1",
               out_valid, out_code, count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_code !== 4'hA || count !== 3'd1) begin
        errors++;
        $display("FAIL latency_hold%0d: got v=%b code=%h cnt=%0d want v=1 code=a cnt=1",
                 i, out_valid, out_code, count);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_code !== 4'h0) begin
      errors++;
      $display("FAIL latency_midreset: got v=%b cnt=%0d code=%h want v=0 cnt=0 code=0",
               out_valid, count, out_code);
    end
    $display("test_latency: done");
  endtask

  task automatic test_order_wrap();
    logic [3:0] exp;
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL order_fill_count: got %0d want 4", count);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = 4'(i);
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp) begin
        errors++;
        $display("FAIL order_pop%0d: got v=%b code=%h want v=1 code=%h", i, out_valid, out_code, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_drained: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
    end
    for (int i = 5; i <= 7; i++) push(4'(i));
    out_ready = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      exp = 4'(i);
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp) begin
        errors++;
        $display("FAIL order_wrap_pop%0d: got v=%b code=%h want v=1 code=%h", i, out_valid, out_code, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_code !== 4'h0) begin
      errors++;
      $display("FAIL order_wrap_drained: got cnt=%0d code=%h want cnt=0 code=0", count, out_code);
    end
    $display("test_order_wrap: done");
  endtask

  task automatic test_overflow();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'h2; exp_seq[1] = 4'h3; exp_seq[2] = 4'h4; exp_seq[3] = 4'h9;
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    push(4'h9);
    checks++;
    if (count !== 3'd4 || overflow !== 1'b1 || out_code !== 4'h1) begin
      errors++;
      $display("FAIL ovf_drop: got cnt=%0d ovf=%b code=%h want cnt=4 ovf=1 code=1", count, overflow, out_code);
    end
    // Full FIFO, push with concurrent pop: accepted, no overflow change.
    out_ready = 1'b1;
    push(4'h9);
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd4 || out_code !== 4'h2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pushpop_full: got cnt=%0d code=%h ovf=%b want cnt=4 code=2 ovf=1", count, out_code, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_code !== exp_seq[i]) begin
        errors++;
        $display("FAIL ovf_drain%0d: got v=%b code=%h want v=1 code=%h", i, out_valid, out_code, exp_seq[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got cnt=%0d ovf=%b want cnt=0 ovf=1", count, overflow);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got ovf=%b want 0", overflow);
    end
    $display("test_overflow: done");
  endtask

  task automatic test_holdoff();
    do_reset();
    push(4'h5);                    // edge 0, timer loads 10
    repeat (3) tick();             // edges 1..3
    push(4'h5);                    // edge 4, timer still 7
    checks++;
    if (suppressed !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL holdoff_suppress: got sup=%b cnt=%0d want sup=1 cnt=1", suppressed, count);
    end
    tick();                        // edge 5
    checks++;
    if (suppressed !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_pulse_width: got sup=%b want 0", suppressed);
    end
    repeat (6) tick();             // edges 6..11, timer expired at edge 10
    push(4'h5);                    // edge 12
    checks++;
    if (suppressed !== 1'b0 || count !== 3'd2) begin
      errors++;
      $display("FAIL holdoff_expired: got sup=%b cnt=%0d want sup=0 cnt=2", suppressed, count);
    end
    push(4'h6);                    // edge 13, different code
    checks++;
    if (suppressed !== 1'b0 || count !== 3'd3) begin
      errors++;
      $display("FAIL holdoff_other_code: got sup=%b cnt=%0d want sup=0 cnt=3", suppressed, count);
    end
    $display("test_holdoff: done");
  endtask

  task automatic test_simul_empty();
    do_reset();
    out_ready = 1'b1;
    push(4'h3);
    checks++;
    if (count !== 3'd1 || out_code !== 4'h3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty: got cnt=%0d code=%h v=%b want cnt=1 code=3 v=1", count, out_code, out_valid);
    end
    push(4'h7);
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd1 || out_code !== 4'h7) begin
      errors++;
      $display("FAIL simul_one: got cnt=%0d code=%h want cnt=1 code=7", count, out_code);
    end
    $display("test_simul_empty: done");
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i));
    push(4'h8);                    // dropped, sets overflow
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got cnt=%0d ovf=%b want cnt=3 ovf=1", count, overflow);
    end
    clear = 1'b1;
    push(4'h5);
    clear = 1'b0;
    checks++;
    if (count !== 3'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || out_code !== 4'h0) begin
      errors++;
      $display("FAIL clear_flush: got cnt=%0d ovf=%b v=%b code=%h want cnt=0 ovf=0 v=0 code=0",
               count, overflow, out_valid, out_code);
    end
    tick();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL clear_no_store: got cnt=%0d want 0", count);
    end
    $display("test_clear: done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_order_wrap();
    test_overflow();
    test_holdoff();
    test_simul_empty();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
